// File: rtl/cfg_write_scheduler.sv
// ---------------------------------------------------------------------------
// cfg_write_scheduler
//
// Merges byte-wide configuration writes from two requesters (host and
// sweep/sequencer) into a small in-order FIFO. The FIFO is drained at most
// one entry per synth frame, in the frame_state slot COMMIT_STATE, so
// register updates never land in the middle of a voice computation.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset
//   frame_state  synth sequencer state 0..7
//   host_valid / host_addr / host_data / host_ready
//                host byte-write request channel
//   seq_valid  / seq_addr  / seq_data  / seq_ready
//                sequencer byte-write request channel
//                addr[3:1] = cfg word address, addr[0] = byte select
//   cfg_we       byte enables to the cfg register file ([0] low, [1] high)
//   cfg_w_addr   cfg word address
//   cfg_w_data   write byte replicated in both halves
//   fifo_count   number of queued entries, 0..DEPTH
// ---------------------------------------------------------------------------

// Runtime invariants of the scheduler, kept apart from the datapath.
module cfg_write_scheduler_chk #(
    parameter int DEPTH = 4
) (
    input logic       clk,
    input logic       reset,
    input logic       host_valid,
    input logic       host_ready,
    input logic       seq_valid,
    input logic       seq_ready,
    input logic [1:0] cfg_we,
    input logic [3:0] fifo_count
);

    a_single_ready: assert property (@(posedge clk) !(host_ready && seq_ready));

    a_host_ready_needs_valid: assert property (@(posedge clk) host_ready |-> host_valid);

    a_seq_ready_needs_valid: assert property (@(posedge clk) seq_ready |-> seq_valid);

    a_count_bound: assert property (@(posedge clk) 32'(fifo_count) <= DEPTH);

    a_single_byte_enable: assert property (@(posedge clk) cfg_we != 2'b11);

    a_reset_quiet: assert property (@(posedge clk)
        reset |-> (!host_ready && !seq_ready && (cfg_we == 2'b00)));

endmodule

module cfg_write_scheduler #(
    parameter int DEPTH        = 4,
    parameter int COMMIT_STATE = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  frame_state,
    input  logic        host_valid,
    input  logic [3:0]  host_addr,
    input  logic [7:0]  host_data,
    output logic        host_ready,
    input  logic        seq_valid,
    input  logic [3:0]  seq_addr,
    input  logic [7:0]  seq_data,
    output logic        seq_ready,
    output logic [1:0]  cfg_we,
    output logic [2:0]  cfg_w_addr,
    output logic [15:0] cfg_w_data,
    output logic [3:0]  fifo_count
);

    localparam int         PTR_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C        = 4'(DEPTH);
    localparam logic [2:0] COMMIT_STATE_C = 3'(COMMIT_STATE);

    // FIFO entry layout: {addr[3:0], data[7:0]}
    logic [11:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [3:0]       count_r;

    // Set when the most recent accept came from the host. Cleared at reset
    // so the host wins the first tie.
    logic             last_host_r;

    logic             full_s;
    logic             empty_s;
    logic             grant_host_s;
    logic             grant_seq_s;
    logic             room_s;
    logic             accept_host_s;
    logic             accept_seq_s;
    logic             push_s;
    logic             pop_s;
    logic [11:0]      push_entry_s;
    logic [11:0]      head_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == 4'd0);
    assign head_s  = mem_r[rd_ptr_r];

    // Round-robin grant between the two requesters; no grant when idle.
    always_comb begin
        grant_host_s = 1'b0;
        grant_seq_s  = 1'b0;
        if (host_valid && seq_valid) begin
            grant_host_s = !last_host_r;
            grant_seq_s  = last_host_r;
        end else if (host_valid) begin
            grant_host_s = 1'b1;
        end else if (seq_valid) begin
            grant_seq_s = 1'b1;
        end else begin
            grant_host_s = 1'b0;
            grant_seq_s  = 1'b0;
        end
    end

    // Ready only to the granted side, and only while a slot is free. A full
    // FIFO keeps ready low even in the commit cycle: the slot freed by the
    // pop becomes usable one cycle later.
    always_comb begin
        room_s        = !full_s && !reset;
        host_ready    = grant_host_s && room_s;
        seq_ready     = grant_seq_s && room_s;
        accept_host_s = host_valid && host_ready;
        accept_seq_s  = seq_valid && seq_ready;
        push_s        = accept_host_s || accept_seq_s;
    end

    // Select the payload of whichever requester was accepted.
    always_comb begin
        push_entry_s = 12'h000;
        if (accept_host_s) begin
            push_entry_s = {host_addr, host_data};
        end else if (accept_seq_s) begin
            push_entry_s = {seq_addr, seq_data};
        end else begin
            push_entry_s = 12'h000;
        end
    end

    // Commit decision uses only registered FIFO state, so an entry pushed in
    // the commit slot cannot bypass straight to the register file.
    always_comb begin
        pop_s      = !reset && !empty_s && (frame_state == COMMIT_STATE_C);
        cfg_w_addr = head_s[11:9];
        cfg_w_data = {head_s[7:0], head_s[7:0]};
        if (pop_s) begin
            cfg_we = head_s[8] ? 2'b10 : 2'b01;
        end else begin
            cfg_we = 2'b00;
        end
    end

    assign fifo_count = count_r;

    // FIFO storage: written at the write pointer on every accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 12'h000;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= PTR_W'(wr_ptr_r + 1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= PTR_W'(rd_ptr_r + 1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + {3'b000, push_s} - {3'b000, pop_s};
        end
    end

    // Round-robin history advances only on a real accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_host_r <= 1'b0;
        end else if (accept_host_s) begin
            last_host_r <= 1'b1;
        end else if (accept_seq_s) begin
            last_host_r <= 1'b0;
        end else begin
            last_host_r <= last_host_r;
        end
    end

    cfg_write_scheduler_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .seq_valid  (seq_valid),
        .seq_ready  (seq_ready),
        .cfg_we     (cfg_we),
        .fifo_count (fifo_count)
    );

endmodule
